// File: rtl/aes_inv_key_sched.sv
// AES-128 inverse key-schedule sequencer: loads the last round key and streams
// round keys NR..0 backwards over a valid/ready handshake, one step per accept.
module aes_inv_key_sched #(
  parameter int         NR       = 10,
  parameter logic [7:0] CNT_BASE = 8'h14
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_last,
  input  logic         abort,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk,
  output logic [3:0]   rk_round,
  output logic         done
);

  typedef enum logic [1:0] {IDLE, EMIT, FIN} state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] rcon_of(input logic [7:0] r);
    logic [7:0] rc;
    case (r)
      8'd1:    rc = 8'h01;
      8'd2:    rc = 8'h02;
      8'd3:    rc = 8'h04;
      8'd4:    rc = 8'h08;
      8'd5:    rc = 8'h10;
      8'd6:    rc = 8'h20;
      8'd7:    rc = 8'h40;
      8'd8:    rc = 8'h80;
      8'd9:    rc = 8'h1b;
      8'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  // One backward expansion step; count encodes the Rcon index as CNT_BASE - r.
  function automatic logic [127:0] step(input logic [127:0] k, input logic [7:0] count);
    logic [31:0] w0, w1, w2, w3, p0, p1, p2, p3;
    {w0, w1, w2, w3} = k;
    p3 = w3 ^ w2;
    p2 = w2 ^ w1;
    p1 = w1 ^ w0;
    p0 = w0 ^ sub_word({p3[23:0], p3[31:24]}) ^ {rcon_of(CNT_BASE - count), 24'h0};
    return {p0, p1, p2, p3};
  endfunction

  state_t       state_q, state_d;
  logic [127:0] key_p0;
  logic [3:0]   round_p0;
  logic         load, adv;
  logic [7:0]   count;

  assign count    = CNT_BASE - {4'b0000, round_p0};
  assign rk       = key_p0;
  assign rk_round = round_p0;

  // abort outranks both start in IDLE and an accept in EMIT.
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    adv      = 1'b0;
    busy     = 1'b1;
    rk_valid = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start && !abort) begin
          load    = 1'b1;
          state_d = EMIT;
        end
      end
      EMIT: begin
        rk_valid = 1'b1;
        if (abort) begin
          state_d = IDLE;
        end else if (rk_ready) begin
          if (round_p0 != 4'd0) adv = 1'b1;
          else                  state_d = FIN;
        end
      end
      FIN: begin
        done    = !abort;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      key_p0   <= '0;
      round_p0 <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        key_p0   <= key_last;
        round_p0 <= 4'(NR);
      end else if (adv) begin
        key_p0   <= step(key_p0, count);
        round_p0 <= round_p0 - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Bench for aes_inv_key_sched: expected keys come from a forward AES-128 key
// expansion whose S-box is derived from GF(2^8) inversion plus the affine map.
module tb_aes_inv_key_sched;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, abort, rk_ready, busy, rk_valid, done;
  logic [127:0] key_last, rk;
  logic [3:0]   rk_round;
  logic         start1, abort1, rk_ready1, busy1, rk_valid1, done1;
  logic [127:0] key_last1, rk1;
  logic [3:0]   rk_round1;

  always #5 clk = ~clk;

  aes_inv_key_sched #(.NR(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_last(key_last), .abort(abort),
    .busy(busy), .rk_valid(rk_valid), .rk_ready(rk_ready), .rk(rk),
    .rk_round(rk_round), .done(done));

  aes_inv_key_sched #(.NR(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .key_last(key_last1), .abort(abort1),
    .busy(busy1), .rk_valid(rk_valid1), .rk_ready(rk_ready1), .rk(rk1),
    .rk_round(rk_round1), .done(done1));

  int total = 0;
  int bad   = 0;

  function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // ---------------- reference model ----------------
  logic [7:0]   sbox_m [256];
  logic [127:0] sched  [11];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      b = {1'b0, b[7:1]};
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Standard forward expansion: sched[r] is round key r of cipher key k0.
  task automatic expand(input logic [127:0] k0);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k0[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) sched[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- stream harness (NR = 10 instance) ----------------
  logic [3:0]   br [$];
  logic [127:0] bk [$];
  int           bcyc [$];
  int           done_cyc, done_cnt;
  bit           aborted;

  task automatic run(input logic [127:0] kl, input bit rnd_ready, input int start_at,
                     input logic [127:0] kalt, input int abort_at);
    logic [127:0] hold_k;
    logic [3:0]   hold_r;
    bit           hold, started, fin;
    hold = 0; started = 0; fin = 0;
    hold_k = '0; hold_r = '0;
    br.delete(); bk.delete(); bcyc.delete();
    done_cyc = -1; done_cnt = 0; aborted = 0;
    @(negedge clk);
    key_last = kl; start = 1'b1; abort = 1'b0; rk_ready = 1'b0;
    for (int c = 1; c <= 400 && !fin; c++) begin
      @(negedge clk);
      start    = 1'b0;
      abort    = 1'b0;
      rk_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rk_valid && int'(rk_round) == abort_at) begin
        abort = 1'b1; rk_ready = 1'b1;
      end
      if (rk_valid && int'(rk_round) == start_at && !started) begin
        start = 1'b1; key_last = kalt; started = 1;
      end
      #1;
      if (hold) begin
        check("hold_rk", rk, hold_k);
        check("hold_round", 128'(rk_round), 128'(hold_r));
        check("hold_valid", 128'(rk_valid), 128'(1));
      end
      hold = 0;
      if (done_cyc >= 0) begin
        check("done_width", 128'(done), 128'(0));
        check("idle_after_done", 128'(busy), 128'(0));
        fin = 1;
      end else if (abort) begin
        aborted = 1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        check("abort_busy", 128'(busy), 128'(0));
        check("abort_valid", 128'(rk_valid), 128'(0));
        check("abort_done", 128'(done), 128'(0));
        check("abort_no_step", 128'(rk_round), 128'(abort_at));
        fin = 1;
      end else begin
        if (done) begin
          done_cnt++;
          done_cyc = c;
        end
        if (rk_valid && rk_ready) begin
          br.push_back(rk_round); bk.push_back(rk); bcyc.push_back(c);
        end else if (rk_valid) begin
          hold = 1; hold_k = rk; hold_r = rk_round;
        end
      end
    end
    if (!fin) begin
      total++; bad++;
      $display("FAIL run_timeout: got no done/abort within 400 cycles, expected completion");
    end
    start = 1'b0; abort = 1'b0; rk_ready = 1'b0;
  endtask

  task automatic verify(input string tag);
    check({tag, "_beats"}, 128'(bk.size()), 128'(11));
    check({tag, "_done_cnt"}, 128'(done_cnt), 128'(1));
    for (int i = 0; i < bk.size() && i < 11; i++) begin
      check({tag, "_round"}, 128'(br[i]), 128'(10 - i));
      check({tag, "_key"}, bk[i], sched[10 - i]);
    end
  endtask

  // ---------------- NR = 1 instance ----------------
  logic [127:0] b1k [$];
  logic [3:0]   b1r [$];

  task automatic run1(input logic [127:0] kl, input logic [127:0] k0_exp, input bit chk_k0);
    int d1;
    d1 = -1;
    b1k.delete(); b1r.delete();
    @(negedge clk);
    key_last1 = kl; start1 = 1'b1; rk_ready1 = 1'b1;
    for (int c = 1; c <= 20 && d1 < 0; c++) begin
      @(negedge clk);
      start1 = 1'b0;
      #1;
      if (done1) d1 = c;
      else if (rk_valid1) begin
        b1k.push_back(rk1); b1r.push_back(rk_round1);
      end
    end
    check("nr1_done_latency", 128'(d1), 128'(3));
    check("nr1_beats", 128'(b1k.size()), 128'(2));
    if (b1k.size() == 2) begin
      check("nr1_round_hi", 128'(b1r[0]), 128'(1));
      check("nr1_round_lo", 128'(b1r[1]), 128'(0));
      check("nr1_key_hi", b1k[0], kl);
      expand(b1k[1]);
      check("nr1_step_roundtrip", sched[1], kl);
      if (chk_k0) check("nr1_key_lo", b1k[1], k0_exp);
    end
    rk_ready1 = 1'b0;
  endtask

  typedef struct {
    int           rnd;
    logic [127:0] key;
  } vec_t;

  vec_t         tbl [4];
  logic [127:0] k0, kl;

  initial begin
    tbl[0] = '{10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    tbl[1] = '{9,  128'hac7766f319fadc2128d12941575c006e};
    tbl[2] = '{1,  128'ha0fafe1788542cb123a339392a6c7605};
    tbl[3] = '{0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
    build_sbox();

    rst_n = 1'b0; start = 1'b1; key_last = rand128(); abort = 1'b0; rk_ready = 1'b1;
    start1 = 1'b0; abort1 = 1'b0; rk_ready1 = 1'b0; key_last1 = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_valid", 128'(rk_valid), 128'(0));
    rst_n = 1'b1; start = 1'b0;
    #1;
    check("rel_busy", 128'(busy), 128'(0));
    check("rel_valid", 128'(rk_valid), 128'(0));
    check("rel_rk", rk, 128'h0);
    check("rel_round", 128'(rk_round), 128'(0));
    check("rel_done", 128'(done), 128'(0));

    // FIPS-197 A.1 with rk_ready held high
    expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
    run(128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 0, -1, '0, -1);
    verify("a1");
    for (int i = 0; i < 4; i++) begin
      int idx;
      idx = 10 - tbl[i].rnd;
      if (idx < bk.size()) begin
        check("a1_tbl_round", 128'(br[idx]), 128'(tbl[i].rnd));
        check("a1_tbl_key", bk[idx], tbl[i].key);
      end else check("a1_tbl_present", 128'(bk.size()), 128'(idx + 1));
    end
    for (int i = 0; i < bcyc.size(); i++) check("a1_consecutive", 128'(bcyc[i]), 128'(i + 1));
    check("a1_start_to_done", 128'(done_cyc), 128'(12));

    run(128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1, -1, '0, -1);
    verify("bp");

    // start during round 5 is ignored and never queued
    run(128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 0, 5, rand128(), -1);
    verify("ign");
    repeat (3) @(negedge clk);
    #1;
    check("ign_stay_idle", 128'(busy), 128'(0));
    check("ign_key_kept", rk, sched[0]);

    run(128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 0, -1, '0, 3);
    check("abort_seen", 128'(aborted), 128'(1));
    check("abort_no_done_pulse", 128'(done_cnt), 128'(0));
    check("abort_beats", 128'(bk.size()), 128'(7));
    k0 = rand128();
    expand(k0);
    run(sched[10], 0, -1, '0, -1);
    verify("post_abort");

    // asynchronous reset in the middle of EMIT
    @(negedge clk);
    key_last = sched[10]; start = 1'b1;
    @(negedge clk);
    start = 1'b0; rk_ready = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 128'(busy), 128'(0));
    check("mid_rst_valid", 128'(rk_valid), 128'(0));
    check("mid_rst_rk", rk, 128'h0);
    check("mid_rst_round", 128'(rk_round), 128'(0));
    check("mid_rst_done", 128'(done), 128'(0));
    @(negedge clk);
    rst_n = 1'b1; rk_ready = 1'b0;

    for (int n = 0; n < 3; n++) begin
      k0 = rand128();
      expand(k0);
      run(sched[10], 1, -1, '0, -1);
      verify("rand");
    end

    run1(128'hd014f9a8c9ee2589e13f0cc8b6630ca6, '0, 0);
    k0 = rand128();
    expand(k0);
    kl = sched[1];
    run1(kl, k0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
